// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int ERRCNT_W  = 8;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == {ERRCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-4 slot counter. 'load0' means the current beat is taken as slot 0,
// so the counter moves straight to 1; 'en' advances by one and wraps 3 -> 0.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  load0,
    output slot_t slot,
    output logic  last
);

    // Slot register: load0 has priority over a plain advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (load0) begin
            slot <= slot_t'(1);
        end else if (en) begin
            slot <= slot + 1'b1;
        end
    end

    assign last = (slot == slot_t'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive end of a 4-slot TDM link: steers beats into four shadow lanes,
// tracks alignment from the slot-0 sync marker, and publishes complete
// frames on registered outputs one cycle after the last beat.
// Optional macro TDM_DEMUX_ERRCNT_EN adds a saturating sync-error counter.
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] d00,
    output logic [WIDTH-1:0] d01,
    output logic [WIDTH-1:0] d10,
    output logic [WIDTH-1:0] d11,
    output logic             frame_valid,
    output slot_t            slot,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    state_t           state;
    state_t           state_next;
    logic             cnt_en;
    logic             cnt_load0;
    logic             last;
    logic             wr_en;
    slot_t            wr_idx;
    logic             complete;
    logic             misalign;
    logic             pend;
    logic [WIDTH-1:0] shadow [NUM_SLOTS];

    tdm_slot_counter u_slot (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .load0 (cnt_load0),
        .slot  (slot),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, shadow write steering, completion and misalignment detect.
    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_load0  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = slot;
        complete   = 1'b0;
        misalign   = 1'b0;
        case (state)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    cnt_load0  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (frame_sync && (slot != '0)) begin
                        // Resynchronise: this beat starts a fresh frame and
                        // the partial one is never published.
                        misalign  = 1'b1;
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        cnt_load0 = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        cnt_en   = 1'b1;
                        complete = last;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Shadow lanes collect the frame under construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_idx] <= din;
        end
    end

    // Completion flag and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pend        <= complete;
            frame_valid <= pend;
            sync_err    <= misalign;
        end
    end

    // Output lanes load the finished frame and hold between frames; a beat
    // landing in shadow lane 0 on the same edge does not disturb the copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            d00 <= '0;
            d01 <= '0;
            d10 <= '0;
            d11 <= '0;
        end else if (pend) begin
            d00 <= shadow[0];
            d01 <= shadow[1];
            d10 <= shadow[2];
            d11 <= shadow[3];
        end
    end

    assign locked = (state == RUN);

`ifdef TDM_DEMUX_ERRCNT_EN
    // Saturating count of misaligned syncs, stepped with the sync_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (misalign) begin
            err_count <= sat_inc(err_count);
        end
    end
`else
    // Error counter not built in this configuration.
`endif

endmodule
